mult_div_ctrl: RTL
==================

# mult_div_ctrl

Sequencing controller between the CPU control unit and the multi-cycle MULT/DIV engines of the MIPS datapath. It accepts one MULT or DIV request at a time and holds the operands stable for the whole operation. It times the multiplier by cycle count and the divider by handshake, then latches the result into the architectural HI/LO registers. It also services MTHI/MTLO writes and reports busy, done, divide-by-zero and divider-timeout status to the control unit.

## Interface
- MULT_LAT, 34, cycles from the first MUL_RUN cycle (mul_start high) to the cycle in which mul_hi/mul_lo hold the final product
- DIV_TIMEOUT, 64, maximum DIV_RUN cycles to wait for div_done before aborting
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  operation request, sampled only in IDLE
- op  in  1  0 = MULT (signed), 1 = DIV (signed)
- rs_val  in  32  operand A; also MTHI/MTLO write data
- rt_val  in  32  operand B
- wr_hi, wr_lo  in  1 each  MTHI / MTLO strobes, honoured only in IDLE
- mul_start  out  1  one-cycle start to multiplier engine
- mul_a, mul_b  out  32 each  multiplier operands, held constant from acceptance to capture
- mul_hi, mul_lo  in  32 each  multiplier product halves
- div_start  out  1  one-cycle start to divider engine
- div_a, div_b  out  32 each  divider operands (dividend, divisor), held as for mul_a/mul_b
- div_done  in  1  divider result-valid strobe
- div_quo, div_rem  in  32 each  quotient, remainder
- hi, lo  out  32 each  architectural HI/LO
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- div0  out  1  one-cycle pulse, coincident with done, for DIV with rt_val = 0
- err  out  1  one-cycle pulse, coincident with done, on divider timeout

## Operation
- States: IDLE, MUL_RUN, DIV_RUN. A 7-bit counter cnt is cleared on every state entry and increments once per RUN cycle.
- IDLE, req & op=0: load operand registers from rs_val/rt_val and go to MUL_RUN.
- IDLE, req & op=1 & rt_val≠0: load operand registers and go to DIV_RUN.
- IDLE, req & op=1 & rt_val=0: stay in IDLE. Pulse done and div0 next cycle. HI/LO unchanged, div_start never asserted.
- MUL_RUN:
  - mul_start = (cnt==0).
  - The engine product is stable for exactly one cycle, the one with cnt==MULT_LAT.
  - At the edge ending that cycle: hi←mul_hi, lo←mul_lo, go to IDLE, done pulses next cycle.
- DIV_RUN:
  - div_start = (cnt==0). div_done is ignored while cnt==0.
  - On div_done with cnt≥1: lo←div_quo, hi←div_rem, go to IDLE, done pulses.
  - If cnt reaches DIV_TIMEOUT without div_done: go to IDLE with HI/LO unchanged; done and err pulse.
- wr_hi/wr_lo in IDLE: hi/lo←rs_val at the edge. May coincide with an accepted req; the later operation result overwrites.
- req, wr_hi and wr_lo while busy are ignored. The control unit must stall on busy.
- Reset (asynchronous, any state): state=IDLE, cnt=0, hi=lo=0, operand regs=0, all pulses/busy/starts=0. A product or quotient still in flight in an engine is never captured.

## Timing
- busy is not high in the cycle req is sampled. It rises the next cycle.
- MULT: busy for MULT_LAT+1 cycles (35 by default). hi/lo are updated at the edge that drops busy, and done is high in that same following cycle.
- DIV: busy for n+1 cycles, where div_done arrives in the n-th cycle after div_start's cycle. hi/lo are already valid when done is high.
- Back-to-back: a req sampled during the done cycle is accepted. There is zero idle gap.
- mul_a/mul_b/div_a/div_b change only at an accepting edge or at reset.

## Test plan
- MULT 7 × 0xFFFFFFFD with the real multiplier engine: mul_start high exactly 1 cycle, busy 35 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done 1 cycle.
- DIV 100/7, divider model asserts div_done 10 cycles after div_start: lo=14, hi=2, busy 11 cycles, div0=err=0.
- wr_hi 0x1234, wr_lo 0x5678, then DIV x/0: done=div0=1 for one cycle, div_start never high, hi=0x1234, lo=0x5678, busy never high.
- DIV with div_done tied low: err=done=1 after 64 RUN cycles, HI/LO unchanged, state IDLE. A following MULT 3×4 gives lo=12, hi=0.
- rst pulsed at cnt=10 of a MULT: busy/mul_start drop asynchronously and hi=lo=0. A new MULT 2×5 then completes with lo=10. A req and wr_hi issued mid-operation have no effect.
- MULT 6×7 followed by a req (DIV 9/2) held during the done cycle: lo=42, then lo=4, hi=1 with no idle cycle between operations.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: sequences one MULT or DIV at a time through the external
// engines, holds their operands, and owns the architectural HI/LO registers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for req / MTHI / MTLO; divide-by-zero resolved here
// S_MUL_RUN | multiplier running; product captured when cnt hits MULT_LAT
// S_DIV_RUN | divider running; wait for div_done or the timeout
module mult_div_ctrl #(
  parameter int MULT_LAT    = 34,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_wr_hi,
  input  logic        i_wr_lo,
  output logic        o_mul_start,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic [31:0] i_mul_hi,
  input  logic [31:0] i_mul_lo,
  output logic        o_div_start,
  output logic [31:0] o_div_a,
  output logic [31:0] o_div_b,
  input  logic        i_div_done,
  input  logic [31:0] i_div_quo,
  input  logic [31:0] i_div_rem,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div0,
  output logic        o_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DIV_RUN = 2'd2
  } state_t;

  localparam logic [6:0] MUL_LAST = 7'(MULT_LAT);
  // The divider gets DIV_TIMEOUT run cycles in total (cnt 0..DIV_TIMEOUT-1);
  // a div_done arriving in the last of them is still honoured.
  localparam logic [6:0] DIV_LAST = 7'(DIV_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_cnt;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;
  logic        r_div0;
  logic        r_err;

  logic        w_load_ops;
  logic        w_cap_mul;
  logic        w_cap_div;
  logic        w_div_zero;
  logic        w_timeout;
  logic        w_wr_en;
  logic        w_mul_start;
  logic        w_div_start;

  // Next-state decode plus the single-cycle control strobes for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load_ops  = 1'b0;
    w_cap_mul   = 1'b0;
    w_cap_div   = 1'b0;
    w_div_zero  = 1'b0;
    w_timeout   = 1'b0;
    w_wr_en     = 1'b0;
    w_mul_start = 1'b0;
    w_div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wr_en = 1'b1;
        if (i_req) begin
          if (!i_op) begin
            w_load_ops  = 1'b1;
            w_state_nxt = S_MUL_RUN;
          end else if (i_rt_val == 32'd0) begin
            w_div_zero = 1'b1;
          end else begin
            w_load_ops  = 1'b1;
            w_state_nxt = S_DIV_RUN;
          end
        end
      end
      S_MUL_RUN: begin
        w_mul_start = (r_cnt == 7'd0);
        if (r_cnt == MUL_LAST) begin
          w_cap_mul   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DIV_RUN: begin
        w_div_start = (r_cnt == 7'd0);
        // div_done in the start cycle belongs to a previous, stale operation.
        if (i_div_done && (r_cnt != 7'd0)) begin
          w_cap_div   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == DIV_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and run counter; the counter restarts on every state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE)) begin
        r_cnt <= 7'd0;
      end else begin
        r_cnt <= r_cnt + 7'd1;
      end
    end
  end

  // Operand hold registers, HI/LO, and the registered status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_opa  <= 32'd0;
      r_opb  <= 32'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_done <= 1'b0;
      r_div0 <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_load_ops) begin
        r_opa <= i_rs_val;
        r_opb <= i_rt_val;
      end
      if (w_wr_en && i_wr_hi) r_hi <= i_rs_val;
      if (w_wr_en && i_wr_lo) r_lo <= i_rs_val;
      if (w_cap_mul) begin
        r_hi <= i_mul_hi;
        r_lo <= i_mul_lo;
      end
      if (w_cap_div) begin
        r_hi <= i_div_rem;
        r_lo <= i_div_quo;
      end
      r_done <= w_cap_mul | w_cap_div | w_timeout | w_div_zero;
      r_div0 <= w_div_zero;
      r_err  <= w_timeout;
    end
  end

  assign o_mul_start = w_mul_start;
  assign o_div_start = w_div_start;
  assign o_mul_a     = r_opa;
  assign o_mul_b     = r_opb;
  assign o_div_a     = r_opa;
  assign o_div_b     = r_opb;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_div0      = r_div0;
  assign o_err       = r_err;

endmodule
